// File: rtl/chronologic.sv
// rtl/chronologic.sv - temporal checker: a at edge k implies b at edge k+DELAY
// Overlapping checks ride a DELAY-deep start pipeline; results feed saturating counters.
module chronologic #(
    parameter int DELAY = 4,
    parameter int CNT_W = 16,
    parameter int TS_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_a,
    input  logic             i_b,
    input  logic             i_clr,
    output logic             o_pass,
    output logic             o_fail,
    output logic [CNT_W-1:0] o_pass_cnt,
    output logic [CNT_W-1:0] o_fail_cnt,
    output logic             o_err_sticky,
    output logic [TS_W-1:0]  o_first_fail_start,
    output logic             o_first_fail_valid,
    output logic [TS_W-1:0]  o_cycle_cnt
);

    logic [DELAY-1:0] r_pipe;
    logic             r_pass;
    logic             r_fail;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic             r_err_sticky;
    logic [TS_W-1:0]  r_first_fail_start;
    logic             r_first_fail_valid;
    logic [TS_W-1:0]  r_cycle_cnt;

    logic w_resolve;
    logic w_pass_ev;
    logic w_fail_ev;

    assign w_resolve = r_pipe[DELAY-1];
    assign w_pass_ev = w_resolve & i_b;
    assign w_fail_ev = w_resolve & ~i_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe             <= '0;
            r_pass             <= 1'b0;
            r_fail             <= 1'b0;
            r_pass_cnt         <= '0;
            r_fail_cnt         <= '0;
            r_err_sticky       <= 1'b0;
            r_first_fail_start <= '0;
            r_first_fail_valid <= 1'b0;
            r_cycle_cnt        <= '0;
        end else begin
            r_pipe[0] <= i_en & i_a;
            for (int i = 1; i < DELAY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
            r_pass      <= w_pass_ev;
            r_fail      <= w_fail_ev;
            r_cycle_cnt <= r_cycle_cnt + TS_W'(1);

            // clr overrides bookkeeping only; the pulses above still fire
            if (i_clr) begin
                r_pass_cnt         <= '0;
                r_fail_cnt         <= '0;
                r_err_sticky       <= 1'b0;
                r_first_fail_start <= '0;
                r_first_fail_valid <= 1'b0;
            end else begin
                if (w_pass_ev && (r_pass_cnt != {CNT_W{1'b1}})) begin
                    r_pass_cnt <= r_pass_cnt + CNT_W'(1);
                end
                if (w_fail_ev && (r_fail_cnt != {CNT_W{1'b1}})) begin
                    r_fail_cnt <= r_fail_cnt + CNT_W'(1);
                end
                if (w_fail_ev) begin
                    r_err_sticky <= 1'b1;
                end
                // pre-edge count minus DELAY is the start edge's count, mod 2^TS_W
                if (w_fail_ev && !r_first_fail_valid) begin
                    r_first_fail_start <= r_cycle_cnt - TS_W'(DELAY);
                    r_first_fail_valid <= 1'b1;
                end
            end
        end
    end

    assign o_pass             = r_pass;
    assign o_fail             = r_fail;
    assign o_pass_cnt         = r_pass_cnt;
    assign o_fail_cnt         = r_fail_cnt;
    assign o_err_sticky       = r_err_sticky;
    assign o_first_fail_start = r_first_fail_start;
    assign o_first_fail_valid = r_first_fail_valid;
    assign o_cycle_cnt        = r_cycle_cnt;

endmodule

// File: tb/tb_chronologic.sv
// tb/tb_chronologic.sv - self-checking bench for chronologic
// Two instances (default, and DELAY=1/CNT_W=4/TS_W=8) share stimulus against an edge-history model.
module tb_chronologic;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0, a = 1'b0, b = 1'b0, clr = 1'b0;

    logic        p0, f0, err0, vld0;
    logic [15:0] pc0, fc0;
    logic [31:0] ffs0, cyc0;
    logic        p1, f1, err1, vld1;
    logic [3:0]  pc1, fc1;
    logic [7:0]  ffs1, cyc1;

    chronologic u_dut0 (
        .clk(clk), .rst_n(rst_n), .i_en(en), .i_a(a), .i_b(b), .i_clr(clr),
        .o_pass(p0), .o_fail(f0), .o_pass_cnt(pc0), .o_fail_cnt(fc0),
        .o_err_sticky(err0), .o_first_fail_start(ffs0),
        .o_first_fail_valid(vld0), .o_cycle_cnt(cyc0)
    );

    chronologic #(.DELAY(1), .CNT_W(4), .TS_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_en(en), .i_a(a), .i_b(b), .i_clr(clr),
        .o_pass(p1), .o_fail(f1), .o_pass_cnt(pc1), .o_fail_cnt(fc1),
        .o_err_sticky(err1), .o_first_fail_start(ffs1),
        .o_first_fail_valid(vld1), .o_cycle_cnt(cyc1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // model: history of started checks indexed by edge number since reset release
    int     n_edge;
    bit     st_h[4096];
    int     dly[2]  = '{4, 1};
    longint cmax[2] = '{65535, 15};
    longint tmsk[2] = '{64'hFFFF_FFFF, 64'hFF};
    bit     e_p[2], e_f[2], e_err[2], e_vld[2];
    longint e_pc[2], e_fc[2], e_ffs[2], e_cyc[2];

    task automatic model_reset();
        n_edge = 0;
        for (int m = 0; m < 2; m++) begin
            e_p[m] = 0; e_f[m] = 0; e_err[m] = 0; e_vld[m] = 0;
            e_pc[m] = 0; e_fc[m] = 0; e_ffs[m] = 0; e_cyc[m] = 0;
        end
    endtask

    task automatic model_edge();
        st_h[n_edge] = en & a;
        for (int m = 0; m < 2; m++) begin
            bit started;
            started = (n_edge >= dly[m]) && st_h[n_edge - dly[m]];
            e_p[m] = started && b;
            e_f[m] = started && !b;
            if (clr) begin
                e_pc[m] = 0; e_fc[m] = 0; e_err[m] = 0; e_vld[m] = 0; e_ffs[m] = 0;
            end else begin
                if (e_p[m] && e_pc[m] < cmax[m]) e_pc[m]++;
                if (e_f[m] && e_fc[m] < cmax[m]) e_fc[m]++;
                if (e_f[m]) e_err[m] = 1;
                if (e_f[m] && !e_vld[m]) begin
                    e_vld[m] = 1;
                    e_ffs[m] = longint'(n_edge - dly[m]) & tmsk[m];
                end
            end
            e_cyc[m] = longint'(n_edge + 1) & tmsk[m];
        end
        n_edge++;
    endtask

    task automatic compare_all();
        check("d0_pass", p0, e_p[0]);   check("d0_fail", f0, e_f[0]);
        check("d0_pcnt", pc0, e_pc[0]); check("d0_fcnt", fc0, e_fc[0]);
        check("d0_err", err0, e_err[0]); check("d0_vld", vld0, e_vld[0]);
        check("d0_ffs", ffs0, e_ffs[0]); check("d0_cyc", cyc0, e_cyc[0]);
        check("d1_pass", p1, e_p[1]);   check("d1_fail", f1, e_f[1]);
        check("d1_pcnt", pc1, e_pc[1]); check("d1_fcnt", fc1, e_fc[1]);
        check("d1_err", err1, e_err[1]); check("d1_vld", vld1, e_vld[1]);
        check("d1_ffs", ffs1, e_ffs[1]); check("d1_cyc", cyc1, e_cyc[1]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_d0"}, {p0, f0, pc0, fc0, err0, vld0, ffs0[7:0], cyc0[7:0]}, 0);
        check({tag, "_d0_ts"}, {ffs0, cyc0}, 0);
        check({tag, "_d1"}, {p1, f1, pc1, fc1, err1, vld1, ffs1, cyc1}, 0);
    endtask

    // called at a negedge: apply inputs, take one edge, compare at the next negedge
    task automatic step(input bit i_en, input bit i_a, input bit i_b, input bit i_clr);
        en = i_en; a = i_a; b = i_b; clr = i_clr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0; a = 1'b0; b = 1'b0; clr = 1'b0;
        #1;
        check_all_zero("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        check_all_zero("por");
        do_reset();

        // mixed sequence
        for (int k = 0; k <= 24; k++) begin
            step(1'b1, !(k == 7 || k == 8), (k == 6 || k == 7 || k >= 12), 1'b0);
            if (k == 11 || k == 12) check("mix_quiet", {p0, f0}, 2'b00);
            if (k == 5) check("mix_fail5", f0, 1);
            if (k == 20) begin
                check("mix_pcnt20", pc0, 10);
                check("mix_fcnt20", fc0, 5);
                check("mix_ffs20", ffs0, 0);
                check("mix_err20", err0, 1);
            end
        end

        // single check, en dropped while in flight
        do_reset();
        for (int k = 0; k <= 10; k++) begin
            step(k <= 3, k == 3, k == 7, 1'b0);
            if (k == 7) check("endrop_pass7", p0, 1);
        end
        check("endrop_pcnt", pc0, 1);
        check("endrop_fcnt", fc0, 0);

        // clr on the same edge as a fail
        do_reset();
        for (int k = 0; k <= 6; k++) begin
            step(1'b1, k == 0, 1'b0, k == 4);
            if (k == 4) begin
                check("clr_fail_pulse", f0, 1);
                check("clr_fcnt", fc0, 0);
                check("clr_err", err0, 0);
                check("clr_vld", vld0, 0);
            end
        end

        // saturation of the 4-bit counters
        do_reset();
        for (int k = 0; k < 22; k++) step(1'b1, 1'b1, 1'b1, 1'b0);
        check("sat_pcnt_d1", pc1, 15);
        check("sat_pcnt_d0", pc0, 18);

        // reset asserted mid-operation
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("midrst_hold", {p0, f0, p1, f1, cyc0[7:0], cyc1}, 0);
        end
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            check("midrst_nopulse", {p0, f0, p1, f1}, 0);
        end
        check("midrst_cyc", cyc0, 8);

        // minimum delay instance
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("mind_pass", {p1, f1}, 2'b10);

        // randomized run, long enough to wrap the 8-bit timestamp
        do_reset();
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
